// File: rtl/icache.sv
// icache -- direct-mapped, read-only instruction cache, one 32-bit word per line.
//
// Sits between the fetch stage and the instruction port of the byte-serial
// memory controller. Hits return in one cycle at one word per cycle; a miss
// runs a single-word refill through mem_if_read / mem_if_ready, installs the
// line and forwards the word to fetch.
//
// Optional feature: define ICACHE_FLUSH_EN to add the `flush` input, which
// invalidates every line at the clock edge where it is high.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low
//   if_req        in   fetch request, held with stable if_pc until inst_valid
//   if_pc         in   fetch address (bits [1:0] ignored)
//   inst_valid    out  one-cycle pulse, inst holds the requested word
//   inst          out  instruction word
//   flush         in   invalidate all lines (ICACHE_FLUSH_EN only)
//   mem_if_read   out  refill request to the memory controller
//   mem_if_addr   out  word-aligned refill address
//   mem_if_ready  in   controller pulse, mem_if_data valid
//   mem_if_data   in   refill word
//   mem_if_busy   in   controller busy (informational only)
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
`ifdef ICACHE_FLUSH_EN
   input  logic        flush,
`endif
   output logic        mem_if_read,
   output logic [31:0] mem_if_addr,
   input  logic        mem_if_ready,
   input  logic [31:0] mem_if_data,
   input  logic        mem_if_busy
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic {
      S_IDLE,
      S_REFILL
   } state_t;

   state_t                state_q;
   logic [LINES-1:0]      valid_q;
   logic                  inst_valid_q;
   logic [31:0]           inst_q;

   // Tag and data storage are never reset; valid_q alone qualifies them.
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  flush_w;
   logic                  hit;
   logic                  install;
   logic                  unused_ok;

   assign idx = if_pc[INDEX_BITS+1:2];
   assign tag = if_pc[31:INDEX_BITS+2];

`ifdef ICACHE_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A request arriving together with a flush must not hit on a line that
   // is being invalidated in the same edge.
   assign hit = valid_q[idx] && (tag_mem[idx] == tag) && !flush_w;

   // Read drops combinationally in the ready cycle so the controller does
   // not see a fresh request and restart a fetch.
   assign mem_if_read = (state_q == S_REFILL) && !mem_if_ready && reset;
   assign mem_if_addr = {if_pc[31:2], 2'b00};

   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;

   assign install = reset && (state_q == S_REFILL) && mem_if_ready;

   assign unused_ok = ^{mem_if_busy, if_pc[1:0]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
      end else begin
         inst_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (if_req) begin
                  if (hit) begin
                     inst_q       <= data_mem[idx];
                     inst_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_REFILL;
                  end
               end
            end
            S_REFILL: begin
               if (mem_if_ready) begin
                  inst_q       <= mem_if_data;
                  inst_valid_q <= 1'b1;
                  valid_q[idx] <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Placed last so a flush in the ready cycle also suppresses the
         // valid bit of the line being refilled.
         if (flush_w) begin
            valid_q <= '0;
         end
      end
   end

   // Array writes kept apart from the reset logic so the storage maps onto
   // plain RAM. Data written under a simultaneous flush stays invalid.
   always_ff @(posedge clock) begin
      if (install) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= mem_if_data;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios followed by randomized fetch
// traffic, checked against a line-level model of a direct-mapped cache.
// The bench acts as the memory controller, answering refills after a
// chosen latency.
module tb_icache;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic        flush;
   logic        mem_if_read;
   logic [31:0] mem_if_addr;
   logic        mem_if_ready;
   logic [31:0] mem_if_data;
   logic        mem_if_busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: which word address each of the 64 lines holds, and its data.
   bit          m_valid [64];
   logic [29:0] m_word  [64];
   logic [31:0] m_data  [64];

   always #5 clock = ~clock;

   icache #(.INDEX_BITS(6)) dut (
      .clock        (clock),
      .reset        (reset),
      .if_req       (if_req),
      .if_pc        (if_pc),
      .inst_valid   (inst_valid),
      .inst         (inst),
`ifdef ICACHE_FLUSH_EN
      .flush        (flush),
`endif
      .mem_if_read  (mem_if_read),
      .mem_if_addr  (mem_if_addr),
      .mem_if_ready (mem_if_ready),
      .mem_if_data  (mem_if_data),
      .mem_if_busy  (mem_if_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] pc);
      logic [31:0] a;
      a = {pc[31:2], 2'b00};
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int i;
      i = int'(pc[7:2]);
      return m_valid[i] && (m_word[i] == pc[31:2]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One idle cycle (request dropped). inst_valid must be low afterwards.
   task automatic idle(input bit do_flush);
      if_req = 1'b0;
      flush  = do_flush;
      next_cycle();
      flush = 1'b0;
      if (do_flush) model_clear();
      check("idle_valid", 32'(inst_valid), 32'd0);
      $display("idle  flush=%0d", do_flush);
   endtask

   // One fetch transaction, entered and left at a falling edge. The request
   // stays asserted on exit so a following fetch is back-to-back.
   task automatic fetch(input logic [31:0] pc, input int lat, input logic [31:0] rdata,
                        input bit fl_ready);
      int i;
      bit hit;
      i   = int'(pc[7:2]);
      hit = model_hit(pc);
      if_req = 1'b1;
      if_pc  = pc;
      check("idle_noread", 32'(mem_if_read), 32'd0);
      next_cycle();
      if (hit) begin
         check("hit_valid", 32'(inst_valid), 32'd1);
         check("hit_inst", inst, m_data[i]);
         check("hit_noread", 32'(mem_if_read), 32'd0);
         $display("fetch pc=%h hit  inst=%h", pc, inst);
      end else begin
         check("miss_valid", 32'(inst_valid), 32'd0);
         check("miss_read", 32'(mem_if_read), 32'd1);
         check("miss_addr", mem_if_addr, {pc[31:2], 2'b00});
         for (int k = 0; k < lat; k++) begin
            next_cycle();
            check("wait_read", 32'(mem_if_read), 32'd1);
            check("wait_valid", 32'(inst_valid), 32'd0);
         end
         mem_if_ready = 1'b1;
         mem_if_data  = rdata;
         flush        = fl_ready;
         #1;
         check("ready_noread", 32'(mem_if_read), 32'd0);
         next_cycle();
         mem_if_ready = 1'b0;
         mem_if_data  = $urandom;
         flush        = 1'b0;
         check("fill_valid", 32'(inst_valid), 32'd1);
         check("fill_inst", inst, rdata);
         if (fl_ready) begin
            model_clear();
         end else begin
            m_valid[i] = 1'b1;
            m_word[i]  = pc[31:2];
            m_data[i]  = rdata;
         end
         $display("fetch pc=%h miss lat=%0d inst=%h flush=%0d", pc, lat, inst, fl_ready);
      end
   endtask

   initial begin
      logic [31:0] pc;
      reset        = 1'b0;
      if_req       = 1'b0;
      if_pc        = '0;
      flush        = 1'b0;
      mem_if_ready = 1'b0;
      mem_if_data  = '0;
      mem_if_busy  = 1'b0;
      model_clear();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_read", 32'(mem_if_read), 32'd0);
      $display("reset released");

      // First fill, then hits on the same and the neighbouring word.
      fetch(32'h0000_0010, 3, 32'h00A0_0093, 1'b0);
      fetch(32'h0000_0010, 0, 32'h0, 1'b0);
      fetch(32'h0000_0014, 1, mem_word(32'h14), 1'b0);
      fetch(32'h0000_0010, 0, 32'h0, 1'b0);
      fetch(32'h0000_0014, 0, 32'h0, 1'b0);
      fetch(32'h0000_0010, 0, 32'h0, 1'b0);
      idle(1'b0);

      // Same index, different tag: each evicts the other.
      fetch(32'h0000_0110, 2, mem_word(32'h110), 1'b0);
      fetch(32'h0000_0010, 0, 32'h00A0_0093, 1'b0);
      fetch(32'h0000_0210, 1, mem_word(32'h210), 1'b0);

      // Reset while waiting for the refill of 0x10.
      if_req = 1'b1;
      if_pc  = 32'h0000_0010;
      next_cycle();
      check("rr_read", 32'(mem_if_read), 32'd1);
      next_cycle();
      reset = 1'b0;
      #1;
      check("rr_read_drop", 32'(mem_if_read), 32'd0);
      @(negedge clock);
      reset  = 1'b1;
      if_req = 1'b0;
      model_clear();
      check("rr_valid", 32'(inst_valid), 32'd0);
      check("rr_idle", 32'(mem_if_read), 32'd0);
      $display("reset during refill");
      idle(1'b0);
      fetch(32'h0000_0010, 0, 32'h00A0_0093, 1'b0);

      // Byte offset bits are ignored.
      fetch(32'h0000_0003, 2, mem_word(32'h0), 1'b0);
      fetch(32'h0000_0000, 0, 32'h0, 1'b0);
      fetch(32'h0000_0002, 0, 32'h0, 1'b0);

`ifdef ICACHE_FLUSH_EN
      idle(1'b1);
      fetch(32'h0000_0010, 1, 32'h00A0_0093, 1'b0);
      idle(1'b1);
      fetch(32'h0000_0010, 0, 32'h00A0_0093, 1'b0);
      fetch(32'h0000_0014, 2, mem_word(32'h14), 1'b1);
      fetch(32'h0000_0014, 0, mem_word(32'h14), 1'b0);
      fetch(32'h0000_0014, 0, 32'h0, 1'b0);
`endif

      // Randomized traffic over a small set of tags and indices.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            idle(1'b0);
         end else begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pc = pc | 32'h8000_0000;
            fetch(pc, int'($urandom_range(0, 3)), mem_word(pc), 1'b0);
         end
      end
      idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction-fetch port of the byte-serial memory controller. It answers hits in one cycle and returns one instruction per cycle on back-to-back hits. On a miss it sequences one 32-bit word refill through the controller's `if_read`/`if_ready` handshake, installs the word, and forwards it to fetch. One cache line holds one instruction word.

## Interface
Parameters:
- `INDEX_BITS`, 6, index width; the cache has 2^INDEX_BITS lines; tag = `if_pc[31:INDEX_BITS+2]`.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge resets the block.
- `if_req`  in  1  fetch request; held with stable `if_pc` until `inst_valid`.
- `if_pc`  in  32  fetch address; bits [1:0] ignored.
- `inst_valid`  out  1  one-cycle pulse: `inst` holds the word for the last accepted request.
- `inst`  out  32  instruction word.
- `flush`  in  1  invalidate all lines (present only with `ICACHE_FLUSH_EN`).
- `mem_if_read`  out  1  refill request to memory controller.
- `mem_if_addr`  out  32  refill address, `{if_pc[31:2],2'b00}`.
- `mem_if_ready`  in  1  controller one-cycle pulse; `mem_if_data` valid.
- `mem_if_data`  in  32  refill word, little-endian assembled.
- `mem_if_busy`  in  1  controller busy; informational, not used for sequencing.

## Operation
- Storage: per line `valid`, tag (32-INDEX_BITS-2 bits), 32-bit data. Index = `if_pc[INDEX_BITS+1:2]`.
- FSM states: IDLE, REFILL.
- IDLE, `if_req`=0: no action; `inst_valid`<=0.
- IDLE, `if_req`=1, hit (valid[idx] and tag match): `inst`<=data[idx], `inst_valid`<=1; stay IDLE.
- IDLE, `if_req`=1, miss: `inst_valid`<=0; go REFILL.
- REFILL: `mem_if_read` = (state==REFILL) && !`mem_if_ready` && `reset`. It is combinational, so read drops in the ready cycle and the controller does not restart a fetch.
- REFILL, `mem_if_ready`=1: write data/tag, set valid[idx]; `inst`<=`mem_if_data`, `inst_valid`<=1; go IDLE.
- REFILL, `mem_if_ready`=0: wait indefinitely. Controller-side arbitration (data port priority) only stretches the wait.
- A request present in the same cycle as `inst_valid`=1 is a new request (pipelined fetch).
- Changing `if_pc` or dropping `if_req` while in REFILL is illegal. The in-flight refill completes regardless and `inst_valid` still pulses.
- `mem_if_addr` is driven from `if_pc` continuously; it is meaningful only while `mem_if_read`=1.

## Timing
- Reset values: state IDLE, all valid=0, `inst_valid`=0, `inst`=0, `mem_if_read`=0. Tag/data arrays are not reset.
- Reset mid-REFILL: state returns to IDLE at that edge, no line is installed, and `mem_if_read` is 0 from the cycle `reset`=0 is sampled.
- Hit latency: request at cycle t gives `inst_valid` at t+1. Throughput is 1 word/cycle.
- Miss latency: request at t, REFILL and `mem_if_read`=1 from t+1, `mem_if_ready` at r, `inst_valid` at r+1. The cache adds 2 cycles to controller latency.
- A refill to an index overwrites the previous line unconditionally (no replacement choice).

## Configuration
- `ICACHE_FLUSH_EN` defined: `flush` port exists.
  - `flush`=1 clears all valid bits at the edge.
  - In IDLE, a request in a flush cycle is treated as a miss.
  - In REFILL, the refill completes and returns data, but the line is not installed if `flush` is seen in the ready cycle. An earlier flush clears other lines only; the refill line installs normally.
- Undefined: no `flush` port; valid bits are cleared only by reset.

## Test plan
- Reset then `if_req`=1, `if_pc`=0x0000_0010 -> REFILL at t+1, `mem_if_read`=1, `mem_if_addr`=0x10; ready with data 0x00A00093 at r -> `inst_valid`=1, `inst`=0x00A00093 at r+1, `mem_if_read`=0 in cycle r.
- Repeat fetch 0x10, then 0x14 after it is filled -> `inst_valid` every cycle, no `mem_if_read`.
- Conflict with INDEX_BITS=6: fill 0x10, then fetch 0x110 (same index) -> miss and refill; then 0x10 -> miss again.
- `reset`=0 during REFILL before ready -> `mem_if_read`=0 that cycle, IDLE after; refetch 0x10 -> miss.
- Pc 0x03 and 0x00 hit the same line; `mem_if_addr`=0x00 on the miss.
- `ICACHE_FLUSH_EN`: fill 0x10, pulse `flush` -> next fetch 0x10 misses; `flush` in the ready cycle -> `inst` returned, following fetch of the same pc misses.
